// File: rtl/cus19_dm_rd_ctrl.sv
// Custom-19 data-memory read controller: drives the SRAM read port and stalls the pipeline for the read latency.
// Optional one-entry last-read buffer enabled by defining CUS19_DM_RD_CACHE_EN.
module cus19_dm_rd_ctrl #(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 19,
  parameter int DM_DEPTH = 2048,
  parameter int RD_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_rd_req,
  input  logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              flush_in,
  input  logic              dm_wr_en_in,
  input  logic [ADDR_W-1:0] dm_wr_addr_in,
  output logic              dm_rd_en_out,
  output logic [ADDR_W-1:0] dm_rd_addr_out,
  input  logic [DATA_W-1:0] dm_rd_data_in,
  output logic              stall_out,
  output logic              rd_valid_out,
  output logic [DATA_W-1:0] rd_data_out,
  output logic              rd_err_out
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [2:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              err_q;
  logic              accept;
  logic              in_range;
  logic              last_wait;
  logic              fill;
  logic              hit;

  assign accept    = (state == IDLE) && mem_rd_req && !flush_in;
  assign in_range  = ({{(32-ADDR_W){1'b0}}, mem_rd_addr} < 32'(DM_DEPTH));
  assign last_wait = (state == WAIT) && (cnt == 3'(RD_LAT));
  assign fill      = last_wait && !flush_in;

`ifdef CUS19_DM_RD_CACHE_EN
  logic              c_valid;
  logic [ADDR_W-1:0] c_tag;
  logic [DATA_W-1:0] c_data;

  // A same-cycle write to the requested address must not be served from the stale buffer.
  assign hit = c_valid && (c_tag == mem_rd_addr) &&
               !(dm_wr_en_in && (dm_wr_addr_in == mem_rd_addr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_valid <= 1'b0;
      c_tag   <= '0;
      c_data  <= '0;
    end else if (flush_in) begin
      c_valid <= 1'b0;
    end else if (fill) begin
      c_valid <= !(dm_wr_en_in && (dm_wr_addr_in == addr_q));
      c_tag   <= addr_q;
      c_data  <= dm_rd_data_in;
    end else if (dm_wr_en_in && (dm_wr_addr_in == c_tag)) begin
      c_valid <= 1'b0;
    end
  end
`else
  logic unused_wr;
  assign unused_wr = ^{dm_wr_en_in, dm_wr_addr_in};
  assign hit       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= 3'd0;
      addr_q <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == WAIT) ? cnt + 3'd1 : 3'd0;
      if (accept) begin
        addr_q <= mem_rd_addr;
        err_q  <= !in_range;
        if (!in_range) begin
          data_q <= '0;
        end else if (hit) begin
`ifdef CUS19_DM_RD_CACHE_EN
          data_q <= c_data;
`endif
        end
      end else if (fill) begin
        data_q <= dm_rd_data_in;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    stall_out    = accept;
    dm_rd_en_out = 1'b0;
    rd_valid_out = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = (!in_range || hit) ? RESP : WAIT;
      end
      WAIT: begin
        stall_out    = 1'b1;
        dm_rd_en_out = (cnt == 3'd0);
        if (flush_in)       state_nxt = IDLE;
        else if (last_wait) state_nxt = RESP;
      end
      RESP: begin
        rd_valid_out = !flush_in;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rd_err_out     = rd_valid_out && err_q;
  assign rd_data_out    = data_q;
  assign dm_rd_addr_out = addr_q;

endmodule

// File: tb/tb_cus19_dm_rd_ctrl.sv
// Scoreboard bench for cus19_dm_rd_ctrl (DM_DEPTH=1024, RD_LAT=1); expectations follow CUS19_DM_RD_CACHE_EN.
module tb_cus19_dm_rd_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_rd_req;
  logic [10:0] mem_rd_addr;
  logic        flush_in;
  logic        dm_wr_en_in;
  logic [10:0] dm_wr_addr_in;
  logic        dm_rd_en_out;
  logic [10:0] dm_rd_addr_out;
  logic [18:0] dm_rd_data_in = '0;
  logic        stall_out;
  logic        rd_valid_out;
  logic [18:0] rd_data_out;
  logic        rd_err_out;

  int compared   = 0;
  int mismatched = 0;

  logic [19:0] rsp_q[$];
  logic        check_ctl  = 1'b0;
  logic        check_zero = 1'b0;
  logic        check_end  = 1'b0;
  logic        exp_stall, exp_en, exp_valid;
  logic [10:0] exp_addr;

`ifdef CUS19_DM_RD_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  cus19_dm_rd_ctrl #(.ADDR_W(11), .DATA_W(19), .DM_DEPTH(1024), .RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
    .flush_in(flush_in), .dm_wr_en_in(dm_wr_en_in), .dm_wr_addr_in(dm_wr_addr_in),
    .dm_rd_en_out(dm_rd_en_out), .dm_rd_addr_out(dm_rd_addr_out), .dm_rd_data_in(dm_rd_data_in),
    .stall_out(stall_out), .rd_valid_out(rd_valid_out), .rd_data_out(rd_data_out),
    .rd_err_out(rd_err_out)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] mem_word(input logic [10:0] a);
    case (a)
      11'd45:  mem_word = 19'h1A2B3;
      11'd200: mem_word = 19'h0BEEF;
      11'd25:  mem_word = 19'h12345;
      11'd10:  mem_word = 19'h0AAAA;
      11'd11:  mem_word = 19'h05555;
      default: mem_word = 19'h0;
    endcase
  endfunction

  // Single-cycle-latency SRAM model
  always @(posedge clk) dm_rd_data_in <= dm_rd_en_out ? mem_word(dm_rd_addr_out) : 19'h0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_zero) begin
      checkOutput("zero_rd_en", 32'(dm_rd_en_out), 0);
      checkOutput("zero_rd_addr", 32'(dm_rd_addr_out), 0);
      checkOutput("zero_stall", 32'(stall_out), 0);
      checkOutput("zero_valid", 32'(rd_valid_out), 0);
      checkOutput("zero_data", 32'(rd_data_out), 0);
      checkOutput("zero_err", 32'(rd_err_out), 0);
    end
    if (check_ctl) begin
      checkOutput("stall", 32'(stall_out), 32'(exp_stall));
      checkOutput("rd_en", 32'(dm_rd_en_out), 32'(exp_en));
      checkOutput("valid", 32'(rd_valid_out), 32'(exp_valid));
      if (exp_en) checkOutput("rd_addr", 32'(dm_rd_addr_out), 32'(exp_addr));
    end
    if (rd_valid_out) begin
      if (rsp_q.size() == 0) begin
        checkOutput("unexpected_valid", 32'(rd_data_out), 32'hFFFF_FFFF);
      end else begin
        logic [19:0] e;
        e = rsp_q.pop_front();
        checkOutput("rsp_data", 32'(rd_data_out), 32'(e[18:0]));
        checkOutput("rsp_err", 32'(rd_err_out), 32'(e[19]));
      end
    end
    if (check_end) checkOutput("rsp_queue_empty", 32'(rsp_q.size()), 0);
  end

  // One clock cycle of stimulus with the control-output expectations for that cycle
  task automatic applyStimulus(input logic req, input logic [10:0] addr, input logic flush,
                               input logic wr_en, input logic [10:0] wr_addr,
                               input logic e_stall, input logic e_en, input logic e_valid,
                               input logic zero_chk);
    mem_rd_req    = req;
    mem_rd_addr   = addr;
    flush_in      = flush;
    dm_wr_en_in   = wr_en;
    dm_wr_addr_in = wr_addr;
    exp_stall     = e_stall;
    exp_en        = e_en;
    exp_addr      = addr;
    exp_valid     = e_valid;
    check_ctl     = 1'b1;
    check_zero    = zero_chk;
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic doRead(input logic [10:0] a, input int resp_cycle, input logic en_issued,
                        input logic [18:0] data, input logic err, input logic hold_last);
    rsp_q.push_back({err, data});
    for (int c = 0; c <= resp_cycle; c++)
      applyStimulus((c < resp_cycle) || hold_last, a, 0, 0, 0,
                    c < resp_cycle, en_issued && (c == 1), c == resp_cycle, 0);
  endtask

  initial begin
    rst_n = 1'b0; mem_rd_req = 0; mem_rd_addr = 0; flush_in = 0; dm_wr_en_in = 0; dm_wr_addr_in = 0;
    check_zero = 1'b1;
    @(negedge clk); @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);

    doRead(11'd45, 3, 1, 19'h1A2B3, 0, 0);
    idle(1);

    // Flush during the first wait cycle: no response, next read is normal
    applyStimulus(1, 11'd200, 0, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 11'd200, 1, 0, 0, 1, 1, 0, 0);
    idle(3);
    doRead(11'd25, 3, 1, 19'h12345, 0, 0);
    idle(1);
    if (CACHE) doRead(11'd25, 1, 0, 19'h12345, 0, 0);
    else       doRead(11'd25, 3, 1, 19'h12345, 0, 0);
    applyStimulus(0, 0, 0, 1, 11'd25, 0, 0, 0, 0);
    doRead(11'd25, 3, 1, 19'h12345, 0, 0);
    idle(1);

    // Reset asserted mid-read
    applyStimulus(1, 11'd200, 0, 0, 0, 1, 0, 0, 0);
    applyStimulus(1, 11'd200, 0, 0, 0, 1, 1, 0, 0);
    rst_n = 1'b0; mem_rd_req = 0; check_ctl = 1'b0; check_zero = 1'b1;
    @(negedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    doRead(11'd25, 3, 1, 19'h12345, 0, 0);
    idle(1);

    doRead(11'd1500, 1, 0, 19'h0, 1, 0);
    idle(1);

    // Back-to-back with the request held through RESP
    doRead(11'd10, 3, 1, 19'h0AAAA, 0, 1);
    doRead(11'd11, 3, 1, 19'h05555, 0, 0);
    idle(2);

    check_ctl = 1'b0;
    check_end = 1'b1;
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/cus19_dm_rd_ctrl.md
# cus19_dm_rd_ctrl

Data-memory read controller for the Custom-19 CPU, directly downstream of the data-memory read-address mux. Takes the muxed read request and 11-bit address (immediate for LOAD, stack pointer for SP ops), drives the synchronous data-memory SRAM read port, and stalls the pipeline until the SRAM's fixed read latency has elapsed. It then returns one 19-bit word to writeback with a one-cycle valid pulse. Out-of-range addresses and pipeline flushes are handled without hanging the pipeline.

## Interface
- `ADDR_W`, 11: read address width.
- `DATA_W`, 19: data word width.
- `DM_DEPTH`, 2048: implemented words; addresses `>= DM_DEPTH` are out of range.
- `RD_LAT`, 1: SRAM cycles from sampled `dm_rd_en_out` to valid `dm_rd_data_in`; legal range 1..7.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_rd_req`  in  1  read request from the address mux; held stable while `stall_out`=1.
- `mem_rd_addr`  in  ADDR_W  read address from the address mux.
- `flush_in`  in  1  pipeline flush; aborts an outstanding read.
- `dm_wr_en_in`  in  1  data-memory write strobe (snooped).
- `dm_wr_addr_in`  in  ADDR_W  data-memory write address (snooped).
- `dm_rd_en_out`  out  1  SRAM read enable.
- `dm_rd_addr_out`  out  ADDR_W  SRAM read address.
- `dm_rd_data_in`  in  DATA_W  SRAM read data.
- `stall_out`  out  1  holds the pipeline while a read is in flight.
- `rd_valid_out`  out  1  one-cycle pulse: `rd_data_out` is valid.
- `rd_data_out`  out  DATA_W  returned word.
- `rd_err_out`  out  1  accompanies `rd_valid_out`; the address was out of range.

## Operation
- FSM states:
  - IDLE: accepts a request when `mem_rd_req`=1 and `flush_in`=0, and latches the address.
    - In range: go to WAIT. `dm_rd_en_out`=1 for exactly the first WAIT cycle, with `dm_rd_addr_out` equal to the latched address.
    - Out of range: go straight to RESP with `rd_data_out`=0 and `rd_err_out`=1. No SRAM access is made.
  - WAIT: a 3-bit counter counts RD_LAT+1 cycles. On the last WAIT cycle, `dm_rd_data_in` is captured into `rd_data_out` and the FSM goes to RESP.
  - RESP: `rd_valid_out`=1 and `stall_out`=0. The FSM returns to IDLE unconditionally. The still-present `mem_rd_req` is not re-accepted in RESP.
- `stall_out` = (IDLE & `mem_rd_req` & ~`flush_in`) | WAIT. It is combinational, so the pipeline holds in the request cycle.
- `flush_in` in WAIT: go to IDLE. Captured data is discarded and there is no `rd_valid_out`. The already-issued SRAM read is harmless.
- `flush_in` in RESP: the valid pulse is suppressed.
- `rd_data_out` holds its last value outside RESP. `dm_rd_addr_out` holds the last latched address.

## Timing
- Reset values: state IDLE, counter 0. All outputs are 0: `dm_rd_en_out`, `dm_rd_addr_out`, `stall_out`, `rd_valid_out`, `rd_data_out`, `rd_err_out`.
- Reset asserted mid-read: IDLE immediately, with no valid pulse after release.
- In-range miss, request in cycle 0:
  - `dm_rd_en_out` is high in cycle 1.
  - `stall_out` is high in cycles 0..1+RD_LAT.
  - `rd_valid_out` is high in cycle 2+RD_LAT.
- Out-of-range, request in cycle 0: `stall_out` high in cycle 0; `rd_valid_out` and `rd_err_out` high in cycle 1.
- Back-to-back: a new request in the cycle after RESP is accepted. Throughput is one read per RD_LAT+3 cycles.

## Configuration
- `CUS19_DM_RD_CACHE_EN` defined: adds a one-entry last-read buffer (valid bit, address tag, data word).
  - Fill: the buffer is filled on every completed in-range read.
  - Hit: an IDLE request whose address matches the tag while the buffer is valid, with no same-cycle `dm_wr_en_in` to that address. A hit goes straight to RESP with the buffered data, so `stall_out` is high only in cycle 0 and `rd_valid_out` is high in cycle 1. No `dm_rd_en_out` is issued.
  - Invalidate: `dm_wr_en_in` with `dm_wr_addr_in` equal to the tag clears the valid bit. Reset and `flush_in` also clear it.
- `CUS19_DM_RD_CACHE_EN` undefined: the buffer logic is absent. `dm_wr_en_in` and `dm_wr_addr_in` are ignored, and every in-range read takes the miss path.

## Test plan
- Reset then idle (RD_LAT=1): `rst_n` 0→1 with `mem_rd_req`=0 -> all outputs 0 and `stall_out`=0 for 10 cycles.
- Miss read (RD_LAT=1): `mem_rd_addr`=45, SRAM returns 19'h1A2B3 -> `dm_rd_en_out` in cycle 1 with addr 45; `stall_out` in cycles 0-2; `rd_valid_out` in cycle 3 with `rd_data_out`=19'h1A2B3 and `rd_err_out`=0.
- Out of range (`DM_DEPTH`=1024): address 1500 -> no `dm_rd_en_out`; `rd_valid_out` and `rd_err_out`=1 in cycle 1 with data 0.
- Flush and reset abort: `flush_in` in cycle 1 of a read to address 200 -> IDLE; no `rd_valid_out`; the next request to address 25 completes normally. Repeat with `rst_n` low for cycle 2 -> all outputs 0 and no late pulse.
- Cache (macro on): read address 25 twice -> the second read has `rd_valid_out` in cycle 1 and no `dm_rd_en_out`. After `dm_wr_en_in` to address 25, a third read takes the full miss path.
- Back-to-back: `mem_rd_req` held high with addresses 10 then 11 -> two valid pulses spaced RD_LAT+3 cycles apart, returning the correct words in order.
